// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes
// and the select/control codes driven into the datapath.
package rv32_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10} result_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} src_a_t;
  typedef enum logic [1:0] {SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_t;

  // ALU operation class requested by the FSM; FUNCT defers to funct3/funct7b5.
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} alu_op_t;

  function automatic imm_src_t imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU class plus funct fields to
// ALUControl, and flags funct3 values this core does not implement.
module alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  alu_control,
  output logic       bad_funct
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: bad_funct = 1'b0;
      default:                        bad_funct = 1'b1;
    endcase
    unique case (alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // op5 separates R-type from I-type: addi never subtracts.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I datapath with a shared, stallable
// memory (mem_req/mem_ready handshake) and a single shared ALU.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal
);

  state_t    state;
  alu_op_t   alu_op;
  alu_ctrl_t alu_ctrl_w;
  logic      bad_funct;
  logic      is_alu, op_known, decode_bad;

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(alu_ctrl_w),
    .bad_funct  (bad_funct)
  );

  assign alu_control = alu_ctrl_w;
  assign is_alu      = (op == OP_R) || (op == OP_I);
  assign op_known    = is_alu || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_JAL);
  assign decode_bad  = !op_known || (is_alu && bad_funct);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      unique case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (decode_bad) begin
            if (TRAP_ON_ILLEGAL) begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            case (op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_R:         state <= S_EXECR;
              OP_I:         state <= S_EXECI;
              OP_BEQ:       state <= S_BEQ;
              default:      state <= S_JAL;
            endcase
          end
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR,
        S_EXECI,
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Enables follow mem_ready/zero in the same cycle, so outputs decode from state combinationally.
  always_comb begin
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_WD;
    alu_op     = AOP_ADD;
    imm_src    = imm_src_for(op);
    unique case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = AOP_FUNCT;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // A reset arriving mid-access must release the memory and block any write at once.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs come
// from an instruction-level model of the control sequence and are checked by a monitor.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct packed {
    logic       mem_req, pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       reg_write, illegal;
  } outs_t;

  typedef struct {
    string name;
    outs_t o;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  outs_t      act;

  logic [6:0] i_op;
  logic [2:0] i_f3;
  logic       i_f7;
  exp_t       sb[$];
  int         checks = 0, errors = 0;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, 32'(act), 32'(e.o));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic outs_t idle(input logic [6:0] o);
    outs_t r = '0;
    r.imm_src = imm_of(o);
    return r;
  endfunction

  function automatic bit f3_ok(input logic [2:0] f3);
    return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // One clock cycle: drive this cycle's inputs just after the edge and queue its expectation.
  task automatic step(input string name, input outs_t e, input logic mr, input logic z);
    exp_t x;
    @(posedge clk);
    #1;
    op = i_op; funct3 = i_f3; funct7b5 = i_f7;
    mem_ready = mr; zero = z;
    x.name = name; x.o = e;
    sb.push_back(x);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must react before any edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check({tag, "_rst_mem_req"},   32'(mem_req), 0);
    check({tag, "_rst_mem_write"}, 32'(mem_write), 0);
    check({tag, "_rst_illegal"},   32'(illegal), 0);
    check({tag, "_rst_adr_src"},   32'(adr_src), 0);
    check({tag, "_rst_src_b"},     32'(alu_src_b), 2);
    check({tag, "_rst_result"},    32'(result_src), 2);
    @(negedge clk);
    #1 mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = idle(i_op);
      e.illegal = 1'b1;
      step("trap", e, rnd(), rnd());
    end
    reset_pulse("trap");
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input int wf, input int wm, input logic zb, input bit abort);
    outs_t e;
    i_op = o; i_f3 = f3; i_f7 = f7;
    for (int i = 0; i <= wf; i++) begin
      e = idle(o);
      e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
      e.ir_write = (i == wf); e.pc_write = (i == wf);
      step("fetch", e, i == wf, rnd());
    end
    e = idle(o);
    e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
    step("decode", e, rnd(), rnd());
    if (o == LW || o == SW) begin
      e = idle(o);
      e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
      step("memadr", e, rnd(), rnd());
      for (int i = 0; i <= wm; i++) begin
        e = idle(o);
        e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (o == SW);
        step(o == SW ? "memwrite" : "memread", e, abort ? 1'b0 : 1'(i == wm), rnd());
        if (abort) begin
          reset_pulse("memread");
          return;
        end
      end
      if (o == LW) begin
        e = idle(o);
        e.result_src = 2'b01; e.reg_write = 1'b1;
        step("memwb", e, rnd(), rnd());
      end
    end else if ((o == RT || o == IT) && f3_ok(f3)) begin
      e = idle(o);
      e.alu_src_a = 2'b10; e.alu_src_b = (o == IT) ? 2'b01 : 2'b00;
      e.alu_control = alu_of(o, f3, f7);
      step(o == RT ? "execr" : "execi", e, rnd(), rnd());
      e = idle(o);
      e.reg_write = 1'b1;
      step("aluwb", e, rnd(), rnd());
    end else if (o == BQ) begin
      e = idle(o);
      e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = zb;
      step("beq", e, rnd(), zb);
    end else if (o == JL) begin
      e = idle(o);
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
      step("jal", e, rnd(), rnd());
      e = idle(o);
      e.reg_write = 1'b1;
      step("aluwb", e, rnd(), rnd());
    end else begin
      trap_hold(10);
    end
  endtask

  initial begin
    logic [6:0] kinds [6];
    logic [2:0] goodf3 [4];
    logic [6:0] o;
    logic [2:0] f3;
    kinds  = '{LW, SW, RT, IT, BQ, JL};
    goodf3 = '{3'b000, 3'b010, 3'b110, 3'b111};
    i_op = RT; i_f3 = 3'b000; i_f7 = 1'b0;
    op = RT;
    #3;
    check("reset_mem_req",  32'(mem_req), 0);
    check("reset_pc_write", 32'(pc_write), 0);
    check("reset_illegal",  32'(illegal), 0);
    check("reset_src_b",    32'(alu_src_b), 2);
    check("reset_result",   32'(result_src), 2);
    check("reset_alu",      32'(alu_control), 0);
    @(negedge clk);
    #1 reset = 1'b1;

    issue(RT, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);   // add
    issue(LW, 3'b010, 1'b0, 3, 2, 1'b0, 1'b0);   // lw with stalls
    issue(SW, 3'b010, 1'b0, 0, 1, 1'b0, 1'b0);   // sw, ready on 2nd cycle
    issue(BQ, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0);   // beq taken
    issue(BQ, 3'b000, 1'b0, 1, 0, 1'b0, 1'b0);   // beq not taken
    issue(JL, 3'b101, 1'b1, 0, 0, 1'b0, 1'b0);   // jal
    issue(RT, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0);   // sub
    issue(IT, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0);   // addi, Instr[30]=1

    for (int n = 0; n < 60; n++) begin
      o  = kinds[$urandom_range(0, 5)];
      f3 = (o == RT || o == IT) ? goodf3[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
      issue(o, f3, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), rnd(), 1'b0);
    end

    issue(LW, 3'b010, 1'b0, 1, 0, 1'b0, 1'b1);   // reset mid-MEMREAD
    issue(RT, 3'b111, 1'b0, 0, 0, 1'b0, 1'b0);   // and, straight after reset
    issue(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);  // unknown opcode
    issue(RT, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0);   // unsupported funct3
    issue(IT, 3'b110, 1'b0, 2, 0, 1'b0, 1'b0);   // ori after recovery

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
